cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_pkg.sv | 14 +
 rtl/cdb_fifo.sv | 78 +++++++
 rtl/cdb_arbiter.sv | 136 +++++++++++++
 tb/tb_cdb_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared constants and entry record for the common data bus arbiter
package cdb_pkg;

  localparam int   Q_WIDTH_DEF = 4;
  localparam int   VALUE_W     = 32;
  localparam logic SRC_ALU     = 1'b0;
  localparam logic SRC_SLB     = 1'b1;

  typedef struct packed {
    logic [Q_WIDTH_DEF-1:0] tag;
    logic [VALUE_W-1:0]     value;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - synchronous per-source result queue with count, full and empty
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int DW = Q_WIDTH_DEF + VALUE_W,
  parameter int AW = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          flush_in,
  input  logic          push_in,
  input  logic          pop_in,
  input  logic [DW-1:0] wdata_in,
  output logic [DW-1:0] rdata_out,
  output logic [AW:0]   count_out,
  output logic          full_out,
  output logic          empty_out
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Full comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign full_out  = (count_q == (AW+1)'(DEPTH));
  assign empty_out = (count_q == '0);
  assign count_out = count_q;
  assign rdata_out = mem_q[rd_ptr_q];
  assign do_push   = push_in && !full_out;
  assign do_pop    = pop_in && !empty_out;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_in;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter queuing ALU and SLB results onto one registered CDB
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int Q_WIDTH = Q_WIDTH_DEF,
  parameter int FIFO_AW = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               control_hazard,
  input  logic               alu_valid,
  input  logic [Q_WIDTH-1:0] alu_rob_tag,
  input  logic [31:0]        alu_value,
  output logic               alu_full,
  input  logic               slb_valid,
  input  logic [Q_WIDTH-1:0] slb_rob_tag,
  input  logic [31:0]        slb_value,
  output logic               slb_full,
  output logic               cdb_valid,
  output logic [Q_WIDTH-1:0] cdb_rob_tag,
  output logic [31:0]        cdb_value,
  output logic               cdb_src
);

  localparam int DW = Q_WIDTH + VALUE_W;

  logic               flush, active;
  logic               accept_alu, accept_slb;
  logic               pop_alu, pop_slb, both_pending;
  logic [DW-1:0]      alu_rdata, slb_rdata;
  logic [FIFO_AW:0]   alu_count, slb_count;
  logic               alu_empty, slb_empty;

  logic               rr_q, rr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [Q_WIDTH-1:0] cdb_rob_tag_q, cdb_rob_tag_d;
  logic [31:0]        cdb_value_q, cdb_value_d;
  logic               cdb_src_q, cdb_src_d;

  assign flush  = rdy_in && control_hazard;
  assign active = rdy_in && !control_hazard;

  // Tag 0 marks "no dependency" and must never reach the bus, so it is not queued.
  assign accept_alu = active && alu_valid && !alu_full && (alu_rob_tag != '0);
  assign accept_slb = active && slb_valid && !slb_full && (slb_rob_tag != '0);

  cdb_fifo #(.DW(DW), .AW(FIFO_AW)) u_alu_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush_in  (flush),
    .push_in   (accept_alu),
    .pop_in    (pop_alu),
    .wdata_in  ({alu_rob_tag, alu_value}),
    .rdata_out (alu_rdata),
    .count_out (alu_count),
    .full_out  (alu_full),
    .empty_out (alu_empty)
  );

  cdb_fifo #(.DW(DW), .AW(FIFO_AW)) u_slb_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush_in  (flush),
    .push_in   (accept_slb),
    .pop_in    (pop_slb),
    .wdata_in  ({slb_rob_tag, slb_value}),
    .rdata_out (slb_rdata),
    .count_out (slb_count),
    .full_out  (slb_full),
    .empty_out (slb_empty)
  );

  assign both_pending = (alu_count != '0) && (slb_count != '0);

  always_comb begin
    pop_alu = 1'b0;
    pop_slb = 1'b0;
    if (active) begin
      if (both_pending) begin
        pop_alu = (rr_q == SRC_ALU);
        pop_slb = (rr_q == SRC_SLB);
      end else begin
        pop_alu = !alu_empty;
        pop_slb = !slb_empty;
      end
    end
  end

  always_comb begin
    rr_d          = rr_q;
    cdb_valid_d   = cdb_valid_q;
    cdb_rob_tag_d = cdb_rob_tag_q;
    cdb_value_d   = cdb_value_q;
    cdb_src_d     = cdb_src_q;
    if (flush) begin
      cdb_valid_d = 1'b0;
      rr_d        = SRC_ALU;
    end else if (active) begin
      cdb_valid_d = pop_alu || pop_slb;
      // After a contended grant the loser gets priority next time.
      if (both_pending) begin
        rr_d = ~rr_q;
      end
      if (pop_alu) begin
        {cdb_rob_tag_d, cdb_value_d} = alu_rdata;
        cdb_src_d                    = SRC_ALU;
      end else if (pop_slb) begin
        {cdb_rob_tag_d, cdb_value_d} = slb_rdata;
        cdb_src_d                    = SRC_SLB;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_q          <= SRC_ALU;
      cdb_valid_q   <= 1'b0;
      cdb_rob_tag_q <= '0;
      cdb_value_q   <= '0;
      cdb_src_q     <= SRC_ALU;
    end else begin
      rr_q          <= rr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_tag_q <= cdb_rob_tag_d;
      cdb_value_q   <= cdb_value_d;
      cdb_src_q     <= cdb_src_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_tag = cdb_rob_tag_q;
  assign cdb_value   = cdb_value_q;
  assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed-vector bench for the CDB arbiter
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        control_hazard;
  logic        alu_valid;
  logic [3:0]  alu_rob_tag;
  logic [31:0] alu_value;
  logic        alu_full;
  logic        slb_valid;
  logic [3:0]  slb_rob_tag;
  logic [31:0] slb_value;
  logic        slb_full;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_tag;
  logic [31:0] cdb_value;
  logic        cdb_src;

  int n_vec  = 0;
  int n_miss = 0;

  cdb_arbiter #(.Q_WIDTH(4), .FIFO_AW(2)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .control_hazard (control_hazard),
    .alu_valid      (alu_valid),
    .alu_rob_tag    (alu_rob_tag),
    .alu_value      (alu_value),
    .alu_full       (alu_full),
    .slb_valid      (slb_valid),
    .slb_rob_tag    (slb_rob_tag),
    .slb_value      (slb_value),
    .slb_full       (slb_full),
    .cdb_valid      (cdb_valid),
    .cdb_rob_tag    (cdb_rob_tag),
    .cdb_value      (cdb_value),
    .cdb_src        (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] val_of(input logic src, input int t);
    return (src ? 32'hB000 : 32'hA000) + 32'(t);
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_alu(input logic v, input int t);
    alu_valid   = v;
    alu_rob_tag = 4'(t);
    alu_value   = val_of(1'b0, t);
  endtask

  task automatic drive_slb(input logic v, input int t);
    slb_valid   = v;
    slb_rob_tag = 4'(t);
    slb_value   = val_of(1'b1, t);
  endtask

  task automatic idle_inputs();
    rdy_in         = 1'b1;
    control_hazard = 1'b0;
    drive_alu(1'b0, 0);
    drive_slb(1'b0, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  // exp_tag == 0 means no broadcast expected after this edge.
  task automatic check_bcast(input string tag, input int exp_tag, input logic exp_src);
    if (exp_tag == 0) begin
      check_val({tag, "_valid"}, 32'(cdb_valid), 32'd0);
    end else begin
      check_val({tag, "_valid"}, 32'(cdb_valid), 32'd1);
      check_val({tag, "_tag"}, 32'(cdb_rob_tag), 32'(exp_tag));
      check_val({tag, "_src"}, 32'(cdb_src), 32'(exp_src));
      check_val({tag, "_value"}, cdb_value, val_of(exp_src, exp_tag));
    end
  endtask

  int   e38_tag [6]  = '{0, 1, 5, 2, 6, 0};
  logic e38_src [6]  = '{0, 0, 1, 0, 1, 0};
  int   e39_tag [15] = '{0, 1, 8, 2, 9, 3, 10, 4, 11, 5, 12, 6, 13, 7, 0};
  int   e41_tag [4]  = '{5, 2, 6, 0};
  logic e41_src [4]  = '{1, 0, 1, 0};

  initial begin
    idle_inputs();
    rst_in = 1'b1;
    step();
    step();
    check_val("rst_valid", 32'(cdb_valid), 32'd0);
    check_val("rst_tag", 32'(cdb_rob_tag), 32'd0);
    check_val("rst_value", cdb_value, 32'd0);
    check_val("rst_src", 32'(cdb_src), 32'd0);
    rst_in = 1'b0;
    step();
    check_val("rst_alu_full", 32'(alu_full), 32'd0);
    check_val("rst_slb_full", 32'(slb_full), 32'd0);

    // single ALU result: broadcast only in the cycle after the second edge
    do_reset();
    alu_valid = 1'b1; alu_rob_tag = 4'd3; alu_value = 32'h11;
    step();
    drive_alu(1'b0, 0);
    check_val("lat_e0_valid", 32'(cdb_valid), 32'd0);
    step();
    check_val("lat_e1_valid", 32'(cdb_valid), 32'd1);
    check_val("lat_e1_tag", 32'(cdb_rob_tag), 32'd3);
    check_val("lat_e1_value", cdb_value, 32'h11);
    check_val("lat_e1_src", 32'(cdb_src), 32'd0);
    step();
    check_val("lat_e2_valid", 32'(cdb_valid), 32'd0);
    check_val("lat_e2_hold_tag", 32'(cdb_rob_tag), 32'd3);
    check_val("lat_e2_hold_value", cdb_value, 32'h11);

    // contended round robin: 1,5,2,6
    do_reset();
    for (int e = 0; e < 6; e++) begin
      drive_alu(e < 2, e + 1);
      drive_slb(e < 2, e + 5);
      step();
      check_bcast($sformatf("rr_e%0d", e), e38_tag[e], e38_src[e]);
    end

    // ALU queue fills while sharing the bus; push at e7 hits full and is dropped
    do_reset();
    for (int e = 0; e < 15; e++) begin
      drive_alu(e <= 7, (e < 7) ? e + 1 : 15);
      drive_slb(e <= 5, e + 8);
      step();
      check_bcast($sformatf("full_e%0d", e), e39_tag[e], e39_tag[e] >= 8);
      if (e == 5) begin
        check_val("full_e5_alu_full", 32'(alu_full), 32'd0);
        check_val("full_e5_slb_full", 32'(slb_full), 32'd1);
      end
      if (e == 6) begin
        check_val("full_e6_alu_full", 32'(alu_full), 32'd1);
        check_val("full_e6_slb_full", 32'(slb_full), 32'd0);
      end
      if (e == 7) check_val("full_e7_alu_full", 32'(alu_full), 32'd0);
    end

    // flush with entries queued and a same-cycle push; rr returns to ALU
    do_reset();
    drive_alu(1'b1, 1); drive_slb(1'b1, 5); step();
    drive_alu(1'b1, 2); drive_slb(1'b1, 6); step();
    check_bcast("fl_pre", 1, 1'b0);
    control_hazard = 1'b1;
    drive_alu(1'b1, 4); drive_slb(1'b1, 7); step();
    check_val("fl_valid", 32'(cdb_valid), 32'd0);
    check_val("fl_alu_full", 32'(alu_full), 32'd0);
    check_val("fl_slb_full", 32'(slb_full), 32'd0);
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      step();
      check_val($sformatf("fl_quiet%0d", i), 32'(cdb_valid), 32'd0);
    end
    drive_alu(1'b1, 9); drive_slb(1'b1, 10); step();
    idle_inputs();
    step();
    check_bcast("fl_rr_a", 9, 1'b0);
    step();
    check_bcast("fl_rr_b", 10, 1'b1);

    // rdy_in low freezes everything, including a pending hazard and pushes
    do_reset();
    drive_alu(1'b1, 1); drive_slb(1'b1, 5); step();
    drive_alu(1'b1, 2); drive_slb(1'b1, 6); step();
    rdy_in = 1'b0; control_hazard = 1'b1;
    drive_alu(1'b1, 8); drive_slb(1'b1, 9);
    for (int i = 0; i < 3; i++) begin
      step();
      check_bcast($sformatf("frz%0d", i), 1, 1'b0);
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      step();
      check_bcast($sformatf("frz_drain%0d", i), e41_tag[i], e41_src[i]);
    end

    // tag 0 results are never queued
    do_reset();
    alu_valid = 1'b1; alu_rob_tag = 4'd0; alu_value = 32'hFFFF;
    slb_valid = 1'b1; slb_rob_tag = 4'd0; slb_value = 32'hFFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val($sformatf("tag0_valid%0d", i), 32'(cdb_valid), 32'd0);
    end
    check_val("tag0_alu_full", 32'(alu_full), 32'd0);
    check_val("tag0_slb_full", 32'(slb_full), 32'd0);
    idle_inputs();
    step();
    check_val("tag0_after", 32'(cdb_valid), 32'd0);

    // reset in the middle of draining SLB results
    do_reset();
    drive_slb(1'b1, 1); step();
    drive_slb(1'b1, 2); step();
    check_bcast("mr_pre", 1, 1'b1);
    drive_slb(1'b1, 3);
    rst_in = 1'b1;
    step();
    check_val("mr_valid", 32'(cdb_valid), 32'd0);
    check_val("mr_tag", 32'(cdb_rob_tag), 32'd0);
    check_val("mr_value", cdb_value, 32'd0);
    check_val("mr_src", 32'(cdb_src), 32'd0);
    check_val("mr_alu_full", 32'(alu_full), 32'd0);
    check_val("mr_slb_full", 32'(slb_full), 32'd0);
    rst_in = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("mr_empty%0d", i), 32'(cdb_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
